// File: rtl/grf_wb_queue_pkg.sv
// Shared widths and the queue entry layout for the register-file write-back queue.
package grf_wb_queue_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] pc;
  } wbEntry_t;

endpackage

// File: rtl/grf_fwd_match.sv
// Combinational forwarding lookup: returns the data of the youngest valid entry
// whose register number matches lookupAddr; register 0 never matches.
module grf_fwd_match
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  wbEntry_t          entries [DEPTH],
  input  logic [DEPTH-1:0]  validMask,
  input  logic [PW-1:0]     headPtr,
  input  logic [REG_W-1:0]  lookupAddr,
  output logic              hit,
  output logic [WORD_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk from oldest (head) to youngest; a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if (lookupAddr != REG_ZERO && validMask[idx] && entries[idx].addr == lookupAddr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/grf_wb_queue.sv
// In-order write-back queue in front of the register file write port, with two
// forwarding lookups so decode sees pending values before they are committed.
module grf_wb_queue
  import grf_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [REG_W-1:0]  inAddr,
  input  logic [WORD_W-1:0] inData,
  input  logic [WORD_W-1:0] inPC,
  input  logic              drainStall,
  output logic              regWriteEn,
  output logic [REG_W-1:0]  regWriteAddr,
  output logic [WORD_W-1:0] regWriteData,
  output logic [WORD_W-1:0] regWritePC,
  input  logic [REG_W-1:0]  fwdAddr1,
  input  logic [REG_W-1:0]  fwdAddr2,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic [WORD_W-1:0] fwdData1,
  output logic [WORD_W-1:0] fwdData2,
  output logic [CW-1:0]     count
);

  // Handshake: a request transfers on a rising edge where inValid && inReady.
  // inReady depends only on the registered count, never on drainStall.
  wbEntry_t         store [DEPTH];
  logic [DEPTH-1:0] validQ;
  logic [PW-1:0]    headPtr;
  logic [PW-1:0]    tailPtr;
  logic [CW-1:0]    countQ;
  logic             storeEn;
  logic             notEmpty;
  wbEntry_t         headEntry;

  assign notEmpty   = (countQ != '0);
  assign inReady    = (countQ != CW'(DEPTH));
  assign regWriteEn = notEmpty && !drainStall && !reset;
  // Writes to register 0 are accepted but never stored.
  assign storeEn    = inValid && inReady && (inAddr != REG_ZERO) && !reset;
  assign count      = countQ;

  assign headEntry    = store[headPtr];
  assign regWriteAddr = notEmpty ? headEntry.addr : '0;
  assign regWriteData = notEmpty ? headEntry.data : '0;
  assign regWritePC   = notEmpty ? headEntry.pc   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      countQ  <= '0;
      validQ  <= '0;
    end else begin
      // Head and tail never alias here: drain needs count != 0, enqueue needs count != DEPTH.
      if (regWriteEn) begin
        headPtr         <= headPtr + 1'b1;
        validQ[headPtr] <= 1'b0;
      end
      if (storeEn) begin
        tailPtr         <= tailPtr + 1'b1;
        validQ[tailPtr] <= 1'b1;
      end
      case ({storeEn, regWriteEn})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (storeEn) begin
      store[tailPtr] <= '{addr: inAddr, data: inData, pc: inPC};
    end
  end

  grf_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries    (store),
    .validMask  (validQ),
    .headPtr    (headPtr),
    .lookupAddr (fwdAddr1),
    .hit        (fwdHit1),
    .data       (fwdData1)
  );

  grf_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries    (store),
    .validMask  (validQ),
    .headPtr    (headPtr),
    .lookupAddr (fwdAddr2),
    .hit        (fwdHit2),
    .data       (fwdData2)
  );

endmodule

// File: tb/tb_grf_wb_queue.sv
// Bench for grf_wb_queue: directed scenarios then random traffic, checked
// against a queue-based reference model and an expected-write scoreboard.
module tb_grf_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  inAddr = '0;
  logic [31:0] inData = '0;
  logic [31:0] inPC = '0;
  logic        drainStall = 1'b0;
  logic        regWriteEn;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteData;
  logic [31:0] regWritePC;
  logic [4:0]  fwdAddr1 = '0;
  logic [4:0]  fwdAddr2 = '0;
  logic        fwdHit1;
  logic        fwdHit2;
  logic [31:0] fwdData1;
  logic [31:0] fwdData2;
  logic [2:0]  count;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t mdl_q[$];
  logic [68:0] exp_q[$];

  grf_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inAddr(inAddr), .inData(inData), .inPC(inPC), .drainStall(drainStall),
    .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr),
    .regWriteData(regWriteData), .regWritePC(regWritePC),
    .fwdAddr1(fwdAddr1), .fwdAddr2(fwdAddr2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
    .fwdData1(fwdData1), .fwdData2(fwdData2), .count(count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference lookup: scan pending writes from youngest to oldest.
  task automatic ref_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 5'd0) begin
      for (int i = mdl_q.size() - 1; i >= 0; i--) begin
        if (!h && mdl_q[i].addr == a) begin
          h = 1'b1;
          d = mdl_q[i].data;
        end
      end
    end
  endtask

  // Driver: one cycle of inputs, applied just after the rising edge.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic st, input logic rs,
                       input logic [4:0] f1, input logic [4:0] f2);
    ent_t e;
    @(posedge clk);
    #1;
    inValid = v; inAddr = a; inData = d; inPC = p;
    drainStall = st; reset = rs; fwdAddr1 = f1; fwdAddr2 = f2;
    if (rs) begin
      exp_q.delete();
    end else if (v && mdl_q.size() != DEPTH && a != 5'd0) begin
      e = '{addr: a, data: d, pc: p};
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input logic st);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 32'd0, st, 1'b0, 5'd0, 5'd0);
  endtask

  // Monitor / scoreboard: checks every cycle on the falling edge, then advances the model.
  initial begin : monitor
    int   sz;
    logic exp_en;
    ent_t head;
    ent_t e;
    logic [68:0] w;
    logic h;
    logic [31:0] d;
    @(posedge clk);
    forever begin
      @(negedge clk);
      sz = mdl_q.size();
      exp_en = (sz != 0) && !drainStall && !reset;
      head = (sz != 0) ? mdl_q[0] : '0;
      chk("count", 32'(count), 32'(sz));
      chk("inReady", 32'(inReady), 32'(sz != DEPTH));
      chk("regWriteEn", 32'(regWriteEn), 32'(exp_en));
      chk("regWriteAddr", 32'(regWriteAddr), 32'(head.addr));
      chk("regWriteData", regWriteData, head.data);
      chk("regWritePC", regWritePC, head.pc);
      if (regWriteEn === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL write_unexpected: got write to r%0d expected none at %0t", regWriteAddr, $time);
        end else begin
          w = exp_q.pop_front();
          e = ent_t'(w);
          chk("sb_addr", 32'(regWriteAddr), 32'(e.addr));
          chk("sb_data", regWriteData, e.data);
          chk("sb_pc", regWritePC, e.pc);
        end
      end
      ref_fwd(fwdAddr1, h, d);
      chk("fwdHit1", 32'(fwdHit1), 32'(h));
      chk("fwdData1", fwdData1, d);
      ref_fwd(fwdAddr2, h, d);
      chk("fwdHit2", 32'(fwdHit2), 32'(h));
      chk("fwdData2", fwdData2, d);
      if (reset) begin
        mdl_q.delete();
      end else begin
        if (exp_en) void'(mdl_q.pop_front());
        if (inValid && sz != DEPTH && inAddr != 5'd0) begin
          e = '{addr: inAddr, data: inData, pc: inPC};
          mdl_q.push_back(e);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd0);
    // Single write
    drive(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 1'b0, 5'd5, 5'd3);
    idle(3, 1'b0);
    // Fill to full under stall, 5th request refused, then drain
    for (int i = 1; i <= 4; i++)
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i), 1'b1, 1'b0, 5'd2, 5'd4);
    drive(1'b1, 5'd6, 32'h600, 32'h5000, 1'b1, 1'b0, 5'd6, 5'd1);
    idle(6, 1'b0);
    // Forwarding priority on duplicate register
    drive(1'b1, 5'd7, 32'hA, 32'h6000, 1'b1, 1'b0, 5'd7, 5'd0);
    drive(1'b1, 5'd7, 32'hB, 32'h6004, 1'b1, 1'b0, 5'd7, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd7, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd7, 5'd9);
    idle(3, 1'b0);
    // Zero register is swallowed
    drive(1'b1, 5'd0, 32'hFFFF, 32'h7000, 1'b0, 1'b0, 5'd0, 5'd0);
    idle(2, 1'b0);
    // Simultaneous enqueue and drain with pointer wrap
    drive(1'b1, 5'd10, 32'hC0, 32'h8000, 1'b1, 1'b0, 5'd10, 5'd11);
    drive(1'b1, 5'd11, 32'hC1, 32'h8004, 1'b1, 1'b0, 5'd10, 5'd11);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 5'(12 + i), 32'hD0 + 32'(i), 32'h9000 + 32'(4 * i), 1'b0, 1'b0, 5'(12 + i), 5'd11);
    idle(4, 1'b0);
    // Reset mid-drain
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'(20 + i), 32'hE0 + 32'(i), 32'hA000 + 32'(4 * i), 1'b1, 1'b0, 5'd21, 5'd0);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd21, 5'd20);
    idle(3, 1'b0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom, $urandom,
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8, 1'b0);
    @(negedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grf_wb_queue.md
# grf_wb_queue

Write-side companion of the general register file: a small in-order queue that accepts register-write results from the execute/memory side, buffers them, and drains exactly one per cycle onto the register file's write port. Queued results are visible through two forwarding lookups, so decode-stage readers see the youngest pending value for a register before the register file has committed it. It sits between the result producers (ALU/load/multi-cycle units) and the register file write port.

## Interface

**Parameters**
- DEPTH, 4, number of queue entries; power of two, at least 2.

**Ports**
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all entries.
- inValid  in  1  producer presents a write request this cycle.
- inReady  out  1  queue can accept; equals (count != DEPTH).
- inAddr  in  5  destination register number.
- inData  in  32  value to write.
- inPC  in  32  PC of the producing instruction, carried through for the write trace.
- drainStall  in  1  holds the head entry; no write is issued this cycle.
- regWriteEn  out  1  write strobe to the register file.
- regWriteAddr  out  5  head entry register number.
- regWriteData  out  32  head entry value.
- regWritePC  out  32  head entry PC.
- fwdAddr1, fwdAddr2  in  5 each  lookup addresses (decode read addresses).
- fwdHit1, fwdHit2  out  1 each  a pending entry matches the address.
- fwdData1, fwdData2  out  32 each  value of the youngest matching entry, else 0.
- count  out  log2(DEPTH)+1  number of valid entries.

## Operation

- Accept when inValid && inReady. If inAddr == 0, the request is accepted and discarded; nothing is stored, count is unchanged, and inPC is dropped.
- Storage is a circular buffer with head and tail pointers, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0. Order is strictly FIFO.
- Drain: regWriteEn = (count != 0) && !drainStall && !reset. When regWriteEn is high, the head advances at the clock edge.
- regWriteAddr, regWriteData, and regWritePC are driven combinationally from the head entry. When the queue is empty, they are 0.
- Enqueue and drain in the same cycle: both take effect, and count is unchanged. When full, inReady is 0 even if a drain is in progress; there is no combinational path from drainStall to inReady.
- Forwarding: each lookup compares against all valid entries, including the head being written this cycle. The youngest match (closest to tail) wins.
  - Address 0 never hits. With no match, the lookup returns hit 0 and data 0.
  - An entry accepted at an edge is visible to lookups in the following cycle.
- Duplicate addresses in the queue are legal. Drain writes them in order, so the last write wins in the register file.

## Timing

- Reset values: count 0, inReady 1, regWriteEn 0, regWriteAddr/Data/PC 0, fwdHit1/2 0, fwdData1/2 0.
- Reset asserted mid-operation discards all entries at that edge, and regWriteEn is 0 during the reset cycle.
- Latency, empty queue, no stall:
  - Request accepted at edge k.
  - regWriteEn is high in cycle k..k+1.
  - The register file commits at edge k+1.
- Throughput is one accept and one drain per cycle.
- Forwarding outputs are purely combinational from fwdAddr and the entry state, within the same cycle.

## Structure

- Shared package: REG_W = 5, WORD_W = 32, REG_ZERO = 5'd0, and a packed entry type {addr[4:0], data[31:0], pc[31:0]}.
- Sub-module grf_fwd_match: a combinational youngest-first priority matcher (entries, valid mask, head pointer, address → hit, data). It is instantiated twice.
- The queue core (pointers, count, storage, drain logic) lives in grf_wb_queue.

## Test plan

- Single write: after reset, enqueue (addr 5, data 0x1234, PC 0x3000) → next cycle regWriteEn=1, regWriteAddr=5, regWriteData=0x1234, regWritePC=0x3000. count goes 1→0 at the following edge.
- Fill/full: drainStall=1, enqueue 4 entries (addrs 1..4) → count=4, inReady=0. A 5th request is not accepted. Release the stall → writes 1,2,3,4 on four consecutive cycles, then regWriteEn=0.
- Forwarding priority: stall, enqueue (7, 0xA) then (7, 0xB) → fwdAddr1=7 gives hit 1, data 0xB. fwdAddr2=0 gives hit 0, data 0. fwdAddr2=9 gives hit 0, data 0.
- Zero register: enqueue (0, 0xFFFF) → accepted, count stays 0, regWriteEn stays 0.
- Simultaneous: count=2, no stall, enqueue each cycle for 6 cycles → count holds 2, and writes emerge in order with pointers wrapping past DEPTH-1.
- Reset mid-drain: with 3 entries queued, assert reset for one cycle → regWriteEn=0 that cycle, count=0, and no further writes occur.
